// File: rtl/mems_spi_arbiter_pkg.sv
// rtl/mems_spi_arbiter_pkg.sv - shared state encoding and parameter defaults for the SPI arbiter
package mems_spi_arbiter_pkg;

  localparam int ADDR_W_DEF      = 16;
  localparam int START_WAIT_DEF  = 4;
  localparam int TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mems_spi_arbiter_slot.sv
// rtl/mems_spi_arbiter_slot.sv - per-requester slot: pending bit, latched address, busy and drop
module spi_req_slot
  import mems_spi_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_grant,
  input  logic              i_release,
  output logic              o_pending,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_busy,
  output logic              o_drop
);

  logic              r_pending;
  logic              r_busy;
  logic              r_drop;
  logic [ADDR_W-1:0] r_addr;
  logic              w_accept;

  assign w_accept = i_start && !r_busy;

  // Accept a start only while idle; a start while busy is rejected with a one-cycle drop pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
      r_drop    <= 1'b0;
      r_addr    <= '0;
    end else begin
      r_drop <= i_start && r_busy;
      if (w_accept) begin
        r_pending <= 1'b1;
        r_busy    <= 1'b1;
        r_addr    <= i_addr;
      end else begin
        if (i_grant)   r_pending <= 1'b0;
        if (i_release) r_busy    <= 1'b0;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_addr    = r_addr;
  assign o_busy    = r_busy;
  assign o_drop    = r_drop;

endmodule

// File: rtl/mems_spi_arbiter.sv
// rtl/mems_spi_arbiter.sv - round-robin arbiter of two requesters onto one shared SPI master
module mems_spi_arbiter
  import mems_spi_arbiter_pkg::*;
#(
  parameter int START_WAIT  = START_WAIT_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_start,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req1_start,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              spi_busy,
  input  logic              clr_err,
  output logic              req0_busy,
  output logic              req1_busy,
  output logic              req0_drop,
  output logic              req1_drop,
  output logic              spi_start,
  output logic [ADDR_W-1:0] spi_addr,
  output logic              grant_id,
  output logic              err_timeout
);

  localparam int               CNT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] SW_LIM = CNT_W'(START_WAIT - 1);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last;
  logic              r_spi_start;
  logic              r_grant_id;
  logic              r_err;
  logic [ADDR_W-1:0] r_spi_addr;

  logic              w_pend0;
  logic              w_pend1;
  logic [ADDR_W-1:0] w_addr0;
  logic [ADDR_W-1:0] w_addr1;
  logic              w_grant_vld;
  logic              w_grant_sel;
  logic              w_release;
  logic              w_timeout;

  spi_req_slot #(.ADDR_W(ADDR_W)) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (req0_start),
    .i_addr    (req0_addr),
    .i_grant   (w_grant_vld && !w_grant_sel),
    .i_release (w_release && !r_grant_id),
    .o_pending (w_pend0),
    .o_addr    (w_addr0),
    .o_busy    (req0_busy),
    .o_drop    (req0_drop)
  );

  spi_req_slot #(.ADDR_W(ADDR_W)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (req1_start),
    .i_addr    (req1_addr),
    .i_grant   (w_grant_vld && w_grant_sel),
    .i_release (w_release && r_grant_id),
    .o_pending (w_pend1),
    .o_addr    (w_addr1),
    .o_busy    (req1_busy),
    .o_drop    (req1_drop)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, grant choice and release/timeout decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_vld = 1'b0;
    w_grant_sel = 1'b0;
    w_release   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pend0 || w_pend1) begin
          w_grant_vld = 1'b1;
          w_grant_sel = (w_pend0 && w_pend1) ? !r_last : w_pend1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (spi_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_cnt >= SW_LIM) begin
          w_timeout   = 1'b1;
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!spi_busy) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt >= TO_LIM) begin
          w_timeout   = 1'b1;
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-state cycle counter: cleared on every state change, saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n)                     r_cnt <= '0;
    else if (w_state_nxt != r_state) r_cnt <= '0;
    else if (r_cnt != TO_LIM)        r_cnt <= r_cnt + CNT_W'(1);
  end

  // Registered outputs: start pulse, granted address/owner, round-robin pointer, sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_spi_start <= 1'b0;
      r_spi_addr  <= '0;
      r_grant_id  <= 1'b0;
      r_last      <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      r_spi_start <= w_grant_vld;
      if (w_grant_vld) begin
        r_spi_addr <= w_grant_sel ? w_addr1 : w_addr0;
        r_grant_id <= w_grant_sel;
        r_last     <= w_grant_sel;
      end
      if (w_timeout)    r_err <= 1'b1;
      else if (clr_err) r_err <= 1'b0;
    end
  end

  assign spi_start   = r_spi_start;
  assign spi_addr    = r_spi_addr;
  assign grant_id    = r_grant_id;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_mems_spi_arbiter.sv
// tb/tb_mems_spi_arbiter.sv - self-checking bench for mems_spi_arbiter
module tb_mems_spi_arbiter;

  localparam int AW = 16;
  localparam int SW = 4;
  localparam int TO = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_start, req1_start, spi_busy, clr_err;
  logic [AW-1:0] req0_addr, req1_addr;
  logic          req0_busy, req1_busy, req0_drop, req1_drop;
  logic          spi_start, grant_id, err_timeout;
  logic [AW-1:0] spi_addr;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  mems_spi_arbiter #(.START_WAIT(SW), .TIMEOUT_CYC(TO), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_start  (req0_start),
    .req0_addr   (req0_addr),
    .req1_start  (req1_start),
    .req1_addr   (req1_addr),
    .spi_busy    (spi_busy),
    .clr_err     (clr_err),
    .req0_busy   (req0_busy),
    .req1_busy   (req1_busy),
    .req0_drop   (req0_drop),
    .req1_drop   (req1_drop),
    .spi_start   (spi_start),
    .spi_addr    (spi_addr),
    .grant_id    (grant_id),
    .err_timeout (err_timeout)
  );

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_inputs();
    req0_start = 1'b0;
    req1_start = 1'b0;
    spi_busy   = 1'b0;
    clr_err    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_start(input int max, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int k = 0; k < max; k++) begin
      if (spi_start === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    do_reset();
    flags = {req0_busy, req1_busy, req0_drop, req1_drop, spi_start, grant_id, err_timeout};
    total++; if (flags !== 7'b0) begin bad++; $display("FAIL reset_flags act=%b exp=0000000", flags); end
    total++; if (spi_addr !== '0) begin bad++; $display("FAIL reset_addr act=%h exp=0000", spi_addr); end
  endtask

  task automatic test_single();
    do_reset();
    req0_addr = 16'd8; req0_start = 1'b1;
    tick(); req0_start = 1'b0;
    total++; if (req0_busy !== 1'b1) begin bad++; $display("FAIL single_busy_rise act=%b exp=1", req0_busy); end
    total++; if (spi_start !== 1'b0) begin bad++; $display("FAIL single_start_early act=%b exp=0", spi_start); end
    tick();
    total++; if (spi_start !== 1'b1) begin bad++; $display("FAIL single_start_lat2 act=%b exp=1", spi_start); end
    total++; if (spi_addr !== 16'd8) begin bad++; $display("FAIL single_addr act=%h exp=0008", spi_addr); end
    total++; if (grant_id !== 1'b0) begin bad++; $display("FAIL single_gid act=%b exp=0", grant_id); end
    tick();
    total++; if (spi_start !== 1'b0) begin bad++; $display("FAIL single_start_onecyc act=%b exp=0", spi_start); end
    spi_busy = 1'b1;
    repeat (20) tick();
    spi_busy = 1'b0;
    total++; if (req0_busy !== 1'b1) begin bad++; $display("FAIL single_busy_hold act=%b exp=1", req0_busy); end
    tick();
    total++; if (req0_busy !== 1'b0) begin bad++; $display("FAIL single_busy_fall act=%b exp=0", req0_busy); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL single_no_err act=%b exp=0", err_timeout); end
  endtask

  task automatic test_tie();
    int comp, at;
    bit ok;
    do_reset();
    req0_addr = 16'h5; req1_addr = 16'h1; req0_start = 1'b1; req1_start = 1'b1;
    tick(); req0_start = 1'b0; req1_start = 1'b0;
    tick();
    total++; if (spi_start !== 1'b1) begin bad++; $display("FAIL tie_first_start act=%b exp=1", spi_start); end
    total++; if (grant_id !== 1'b0) begin bad++; $display("FAIL tie_first_gid act=%b exp=0", grant_id); end
    total++; if (spi_addr !== 16'h5) begin bad++; $display("FAIL tie_first_addr act=%h exp=0005", spi_addr); end
    tick(); spi_busy = 1'b1;
    tick(); tick(); spi_busy = 1'b0; comp = cyc;
    tick();
    wait_start(20, at, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL tie_second_timeout act=%b exp=1", ok); end
    total++; if (grant_id !== 1'b1) begin bad++; $display("FAIL tie_second_gid act=%b exp=1", grant_id); end
    total++; if (spi_addr !== 16'h1) begin bad++; $display("FAIL tie_second_addr act=%h exp=0001", spi_addr); end
    total++; if (ok && (at - comp < 2)) begin bad++; $display("FAIL tie_gap act=%0d exp>=2", at - comp); end
    tick(); spi_busy = 1'b1;
    tick(); spi_busy = 1'b0;
    tick();
    total++; if (req1_busy !== 1'b0) begin bad++; $display("FAIL tie_req1_done act=%b exp=0", req1_busy); end
  endtask

  task automatic test_drop();
    int at;
    bit ok;
    do_reset();
    req1_addr = 16'h11; req1_start = 1'b1;
    tick(); req1_start = 1'b0;
    tick();
    tick(); spi_busy = 1'b1;
    tick(); req0_addr = 16'h33; req0_start = 1'b1;
    tick(); req0_addr = 16'h44;
    total++; if (req0_busy !== 1'b1) begin bad++; $display("FAIL drop_accept_busy act=%b exp=1", req0_busy); end
    total++; if (req0_drop !== 1'b0) begin bad++; $display("FAIL drop_first_none act=%b exp=0", req0_drop); end
    tick(); req0_start = 1'b0;
    total++; if (req0_drop !== 1'b1) begin bad++; $display("FAIL drop_pulse act=%b exp=1", req0_drop); end
    tick();
    total++; if (req0_drop !== 1'b0) begin bad++; $display("FAIL drop_once act=%b exp=0", req0_drop); end
    spi_busy = 1'b0;
    tick();
    wait_start(10, at, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL drop_grant_timeout act=%b exp=1", ok); end
    total++; if (grant_id !== 1'b0) begin bad++; $display("FAIL drop_gid act=%b exp=0", grant_id); end
    total++; if (spi_addr !== 16'h33) begin bad++; $display("FAIL drop_addr_kept act=%h exp=0033", spi_addr); end
    tick(); spi_busy = 1'b1;
    tick(); spi_busy = 1'b0;
    tick();
  endtask

  task automatic test_start_timeout();
    int at;
    bit ok;
    do_reset();
    req0_addr = 16'h20; req0_start = 1'b1;
    tick(); req0_start = 1'b0; req1_addr = 16'h21; req1_start = 1'b1;
    tick(); req1_start = 1'b0;
    total++; if (spi_start !== 1'b1) begin bad++; $display("FAIL sto_start act=%b exp=1", spi_start); end
    repeat (SW) tick();
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL sto_err_early act=%b exp=0", err_timeout); end
    tick();
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL sto_err_set act=%b exp=1", err_timeout); end
    total++; if (req0_busy !== 1'b0) begin bad++; $display("FAIL sto_release act=%b exp=0", req0_busy); end
    total++; if (req1_busy !== 1'b1) begin bad++; $display("FAIL sto_req1_pending act=%b exp=1", req1_busy); end
    wait_start(10, at, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL sto_req1_grant_timeout act=%b exp=1", ok); end
    total++; if (grant_id !== 1'b1) begin bad++; $display("FAIL sto_req1_gid act=%b exp=1", grant_id); end
    total++; if (spi_addr !== 16'h21) begin bad++; $display("FAIL sto_req1_addr act=%h exp=0021", spi_addr); end
    tick(); clr_err = 1'b1;
    tick(); clr_err = 1'b0;
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL sto_clr act=%b exp=0", err_timeout); end
    tick();
    tick(); clr_err = 1'b1;
    tick(); clr_err = 1'b0;
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL sto_set_wins act=%b exp=1", err_timeout); end
    total++; if (req1_busy !== 1'b0) begin bad++; $display("FAIL sto_req1_release act=%b exp=0", req1_busy); end
  endtask

  task automatic test_done_timeout();
    int b, at;
    bit found;
    do_reset();
    req0_addr = 16'h55; req0_start = 1'b1;
    tick(); req0_start = 1'b0;
    tick();
    tick(); spi_busy = 1'b1; b = cyc;
    found = 1'b0; at = -1;
    for (int k = 0; k < 1200; k++) begin
      tick();
      if (err_timeout === 1'b1) begin
        found = 1'b1;
        at = cyc;
        break;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL dto_err_never act=%b exp=1", found); end
    total++; if (found && (at - b < TO || at - b > TO + 2)) begin bad++; $display("FAIL dto_err_time act=%0d exp=%0d..%0d", at - b, TO, TO + 2); end
    total++; if (req0_busy !== 1'b0) begin bad++; $display("FAIL dto_release act=%b exp=0", req0_busy); end
    spi_busy = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [6:0] flags;
    do_reset();
    req0_addr = 16'h9; req0_start = 1'b1;
    tick(); req0_start = 1'b0;
    tick();
    tick(); spi_busy = 1'b1;
    tick(); req1_addr = 16'h7; req1_start = 1'b1;
    tick(); req1_start = 1'b0;
    tick();
    total++; if ({req0_busy, req1_busy} !== 2'b11) begin bad++; $display("FAIL rmid_pre act=%b exp=11", {req0_busy, req1_busy}); end
    rst_n = 1'b0; spi_busy = 1'b0;
    tick(); rst_n = 1'b1;
    flags = {req0_busy, req1_busy, req0_drop, req1_drop, spi_start, grant_id, err_timeout};
    total++; if (flags !== 7'b0) begin bad++; $display("FAIL rmid_flags act=%b exp=0000000", flags); end
    total++; if (spi_addr !== '0) begin bad++; $display("FAIL rmid_addr act=%h exp=0000", spi_addr); end
    tick();
    total++; if ({spi_start, req0_drop, req1_drop} !== 3'b0) begin bad++; $display("FAIL rmid_no_pulse act=%b exp=000", {spi_start, req0_drop, req1_drop}); end
    req0_addr = 16'h3; req1_addr = 16'h4; req0_start = 1'b1; req1_start = 1'b1;
    tick(); req0_start = 1'b0; req1_start = 1'b0;
    tick();
    total++; if (spi_start !== 1'b1) begin bad++; $display("FAIL rmid_tie_start act=%b exp=1", spi_start); end
    total++; if (grant_id !== 1'b0) begin bad++; $display("FAIL rmid_tie_gid act=%b exp=0", grant_id); end
    total++; if (spi_addr !== 16'h3) begin bad++; $display("FAIL rmid_tie_addr act=%h exp=0003", spi_addr); end
  endtask

  task automatic test_random();
    bit            m_busy[2], m_pend[2], m_drop[2], cur_b[2];
    int            m_acc[2];
    logic [AW-1:0] m_addr[2];
    bit            m_idle, m_last, m_active, m_owner, exp_start, sel, el0, el1, r0, r1;
    int            m_free, hi_s, hi_len;
    logic [AW-1:0] a0, a1;
    do_reset();
    for (int n = 0; n < 2; n++) begin
      m_busy[n] = 1'b0; m_pend[n] = 1'b0; m_drop[n] = 1'b0; m_acc[n] = 0; m_addr[n] = '0;
    end
    m_idle = 1'b1; m_last = 1'b1; m_active = 1'b0; m_owner = 1'b0;
    m_free = 0; hi_s = 0; hi_len = 0;
    for (int i = 0; i < 600; i++) begin
      total++; if (req0_busy !== m_busy[0]) begin bad++; $display("FAIL rnd_busy0 i=%0d act=%b exp=%b", i, req0_busy, m_busy[0]); end
      total++; if (req1_busy !== m_busy[1]) begin bad++; $display("FAIL rnd_busy1 i=%0d act=%b exp=%b", i, req1_busy, m_busy[1]); end
      total++; if (req0_drop !== m_drop[0]) begin bad++; $display("FAIL rnd_drop0 i=%0d act=%b exp=%b", i, req0_drop, m_drop[0]); end
      total++; if (req1_drop !== m_drop[1]) begin bad++; $display("FAIL rnd_drop1 i=%0d act=%b exp=%b", i, req1_drop, m_drop[1]); end
      total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL rnd_err i=%0d act=%b exp=0", i, err_timeout); end
      el0 = m_pend[0] && (m_acc[0] <= i - 2);
      el1 = m_pend[1] && (m_acc[1] <= i - 2);
      exp_start = m_idle && (m_free <= i - 1) && (el0 || el1);
      total++; if (spi_start !== exp_start) begin bad++; $display("FAIL rnd_start i=%0d act=%b exp=%b", i, spi_start, exp_start); end
      if (exp_start) begin
        sel = (el0 && el1) ? !m_last : el1;
        total++; if (grant_id !== sel) begin bad++; $display("FAIL rnd_gid i=%0d act=%b exp=%b", i, grant_id, sel); end
        total++; if (spi_addr !== m_addr[sel]) begin bad++; $display("FAIL rnd_addr i=%0d act=%h exp=%h", i, spi_addr, m_addr[sel]); end
        m_pend[sel] = 1'b0;
        m_last = sel;
        m_owner = sel;
        m_idle = 1'b0;
        m_active = 1'b1;
        hi_s = i + 1 + int'($urandom_range(0, 2));
        hi_len = int'($urandom_range(1, 6));
      end
      cur_b[0] = m_busy[0];
      cur_b[1] = m_busy[1];
      spi_busy = m_active && (i >= hi_s) && (i < hi_s + hi_len);
      if (m_active && (i == hi_s + hi_len)) begin
        m_busy[m_owner] = 1'b0;
        m_active = 1'b0;
        m_idle = 1'b1;
        m_free = i + 1;
      end
      r0 = ($urandom_range(0, 3) == 0);
      r1 = ($urandom_range(0, 3) == 0);
      a0 = AW'($urandom);
      a1 = AW'($urandom);
      req0_start = r0; req0_addr = a0;
      req1_start = r1; req1_addr = a1;
      if (r0 && !cur_b[0]) begin m_busy[0] = 1'b1; m_pend[0] = 1'b1; m_acc[0] = i; m_addr[0] = a0; end
      if (r1 && !cur_b[1]) begin m_busy[1] = 1'b1; m_pend[1] = 1'b1; m_acc[1] = i; m_addr[1] = a1; end
      m_drop[0] = r0 && cur_b[0];
      m_drop[1] = r1 && cur_b[1];
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    req0_addr = '0;
    req1_addr = '0;
    test_reset();
    test_single();
    test_tie();
    test_drop();
    test_start_timeout();
    test_done_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mems_spi_arbiter.md
MEMS_SPI_ARBITER -- requirements
Module: mems_spi_arbiter

Interface
REQ-001 Parameter START_WAIT, default 4: max cycles from spi_start until spi_busy must rise.
REQ-002 Parameter TIMEOUT_CYC, default 1024: max cycles spi_busy may stay high per transaction.
REQ-003 Parameter ADDR_W, default 16: width of the command-ROM address carried per request.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 req0_start  in  1  scan-controller request pulse, one cycle.
REQ-007 req0_addr  in  ADDR_W  scan command address, sampled with req0_start.
REQ-008 req1_start  in  1  auxiliary/config request pulse, one cycle.
REQ-009 req1_addr  in  ADDR_W  aux command address, sampled with req1_start.
REQ-010 spi_busy  in  1  busy flag from the shared SPI master.
REQ-011 clr_err  in  1  clears err_timeout.
REQ-012 req0_busy, req1_busy  out  1 each  requester has a pending or active transaction.
REQ-013 req0_drop, req1_drop  out  1 each  one-cycle pulse: request rejected.
REQ-014 spi_start  out  1  one-cycle start pulse to the SPI master.
REQ-015 spi_addr  out  ADDR_W  address of the granted command, held from grant until return to IDLE.
REQ-016 grant_id  out  1  requester owning the current transaction.
REQ-017 err_timeout  out  1  sticky handshake-timeout flag.

Function
REQ-018 All outputs shall be registered.
REQ-019 reqN_start shall be accepted only when reqN_busy is 0 that cycle; the address is latched, and reqN_busy shall be 1 from the next cycle.
REQ-020 reqN_start while reqN_busy is 1 shall be ignored, pulsing reqN_drop the next cycle.
REQ-021 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-022 IDLE: if any request is pending, grant it, load spi_addr/grant_id, and go to ISSUE.
REQ-023 If both requests are pending, grant the requester not granted last (round-robin).
REQ-024 After reset, the last-grant pointer shall be 1, so req0 wins the first tie.
REQ-025 ISSUE: spi_start=1 for exactly one cycle; go to WAIT_BUSY.
REQ-026 Latency: accepted request in idle arbiter -> spi_start exactly 2 cycles after reqN_start.
REQ-027 WAIT_BUSY: on spi_busy=1, go to WAIT_DONE.
REQ-028 WAIT_BUSY: if START_WAIT cycles elapse without spi_busy=1, set err_timeout, release the grant, and go to IDLE.
REQ-029 WAIT_DONE: on the first cycle spi_busy=0, the transaction is complete: clear the owner's reqN_busy next cycle and go to IDLE.
REQ-030 WAIT_DONE: if spi_busy remains 1 for TIMEOUT_CYC cycles, set err_timeout, release the grant, and go to IDLE.
REQ-031 Completion -> next spi_start shall be at least 2 cycles apart (back-to-back minimum gap).
REQ-032 The timeout counter shall be sized clog2(TIMEOUT_CYC+1) and reset on every state entry; it shall never wrap.
REQ-033 clr_err shall clear err_timeout next cycle; a simultaneous new timeout shall win (flag stays 1).
REQ-034 A request arriving while the other requester is active shall stay pending; it shall be granted on the next IDLE.
REQ-035 Illegal state encoding shall go to IDLE.

Reset
REQ-036 rst_n=0 at a clock edge: state IDLE; all pending bits, reqN_busy, reqN_drop, spi_start, err_timeout, and grant_id = 0; spi_addr = 0; last-grant = 1.
REQ-037 Reset mid-transaction shall abandon it silently, with no spi_start or drop pulse emitted on the cycle after reset.

Structure
REQ-038 A shared package shall hold the state encoding, the ADDR_W default, and the START_WAIT/TIMEOUT_CYC defaults.
REQ-039 One sub-module, spi_req_slot, shall be instantiated twice; it holds the pending bit, latched address, busy and drop logic.

Verification
REQ-040 req0_start with addr=8 while idle -> spi_start at +2 with spi_addr=8 and grant_id=0; spi_busy high for 20 cycles, then low -> req0_busy falls 1 cycle later.
REQ-041 req0_start and req1_start in the same cycle after reset -> req0 granted first, req1 (addr=1) granted second, spi_start pulses at least 2 cycles apart.
REQ-042 req0_start repeated while req0_busy=1 -> req0_drop pulses once; the pending address is unchanged.
REQ-043 spi_busy never rises after spi_start -> err_timeout=1 after 4 cycles, state IDLE; a pending req1 is then granted; clr_err clears the flag.
REQ-044 spi_busy held high for 1024 cycles -> err_timeout=1 and the grant is released.
REQ-045 rst_n=0 during WAIT_DONE -> next cycle all outputs at reset values and req0 wins the next tie.
